// File: rtl/fibo_sequencer.sv
// fibo_sequencer: computes F(n) mod 2^size by sequencing an external combinational ALU.
module fibo_sequencer #(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [size-1:0] n,
  input  logic [size-1:0] D,
  input  logic            zero_flag,
  output logic [2:0]      opcode,
  output logic [size-1:0] A,
  output logic [size-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] result
);
  typedef enum logic [2:0] {IDLE, LOAD_N, LOAD_ONE, ADD, SHIFT, MOVE, DEC, DONE} state_t;
  state_t state_q, state_d;
  logic [size-1:0] n_q, n_d, cnt_q, cnt_d, f0_q, f0_d, f1_q, f1_d, t_q, t_d, result_q, result_d;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      f0_q     <= '0;
      f1_q     <= '0;
      t_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      f0_q     <= f0_d;
      f1_q     <= f1_d;
      t_q      <= t_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    f0_d     = f0_q;
    f1_d     = f1_q;
    t_d      = t_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        n_d     = n;
        f0_d    = '0;
        state_d = LOAD_N;
      end
      LOAD_N: begin
        cnt_d    = D;
        result_d = zero_flag ? f0_q : result_q;
        state_d  = zero_flag ? DONE : LOAD_ONE;
      end
      LOAD_ONE: begin
        f1_d    = D;
        state_d = ADD;
      end
      ADD: begin
        t_d     = D;
        state_d = SHIFT;
      end
      SHIFT: begin
        f0_d    = D;
        state_d = MOVE;
      end
      MOVE: begin
        f1_d    = D;
        state_d = DEC;
      end
      DEC: begin
        cnt_d    = D;
        result_d = zero_flag ? f0_q : result_q;
        state_d  = zero_flag ? DONE : ADD;
      end
      default: state_d = IDLE;
    endcase
  end
  // Moore decode of the ALU command; unused operands stay 0
  always_comb begin
    opcode = 3'b000;
    A      = '0;
    B      = '0;
    case (state_q)
      LOAD_N:   begin opcode = 3'b111; B = n_q; end
      LOAD_ONE: opcode = 3'b001;
      ADD:      begin opcode = 3'b110; A = f0_q; B = f1_q; end
      SHIFT:    begin opcode = 3'b111; B = f1_q; end
      MOVE:     begin opcode = 3'b100; A = t_q; end
      DEC:      begin opcode = 3'b011; A = cnt_q; end
      default:  opcode = 3'b000;
    endcase
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_fibo_sequencer.sv
// tb_fibo_sequencer: scoreboard bench with a behavioural ALU; monitor checks result, latency and opcode stream per run.
module tb_fibo_sequencer;
  logic       clk = 0;
  logic       reset_n = 0;
  logic       start = 0;
  logic [3:0] n = '0;
  logic [3:0] D, A, B, result;
  logic       zero_flag, busy, done;
  logic [2:0] opcode;
  int errors = 0;
  int checks = 0;
  int runs_done = 0;
  typedef struct {logic [3:0] r; int lat;} exp_t;
  exp_t sb[$];
  logic [3:0] fib [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2, 7, 9, 0, 9, 9, 2};
  logic [2:0] loop_ops [4] = '{3'b110, 3'b111, 3'b100, 3'b011};

  fibo_sequencer #(.size(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n(n), .D(D), .zero_flag(zero_flag),
    .opcode(opcode), .A(A), .B(B), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always_comb begin
    D = 4'd0;
    case (opcode)
      3'b001: D = 4'd1;
      3'b011: D = A - 4'd1;
      3'b100: D = A;
      3'b110: D = A + B;
      3'b111: D = B;
      default: D = 4'd0;
    endcase
  end
  assign zero_flag = D == 4'd0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int cyc = 0;
  bit op_ok = 1;
  always @(negedge clk) begin
    logic [2:0] eop;
    exp_t e;
    if (!reset_n) begin
      cyc = 0;
      op_ok = 1;
    end else if (busy) begin
      cyc++;
      eop = done ? 3'b000 : cyc == 1 ? 3'b111 : cyc == 2 ? 3'b001 : loop_ops[(cyc - 3) % 4];
      if (opcode !== eop) op_ok = 0;
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", int'(result), int'(e.r));
          chk("latency", cyc - 1, e.lat);
          chk("opcode_seq", int'(op_ok), 1);
        end
        cyc = 0;
        op_ok = 1;
        runs_done++;
      end
    end else cyc = 0;
  end

  task automatic wait_runs(input int target);
    int i = 0;
    while (runs_done < target && i < 300) begin
      @(posedge clk);
      i++;
    end
    if (runs_done < target) chk("timeout", runs_done, target);
  endtask

  task automatic run(input logic [3:0] nv);
    int t = runs_done + 1;
    @(negedge clk);
    n = nv;
    start = 1;
    sb.push_back('{fib[nv], nv == 0 ? 1 : 2 + 4 * int'(nv)});
    @(negedge clk);
    start = 0;
    wait_runs(t);
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_opcode", opcode, 0);
    reset_n = 1;
    run(4'd0);
    run(4'd1);
    run(4'd7);
    chk("result_hold", result, 13);
    run(4'd8);
    run(4'd15);
    run(4'd7);
    @(negedge clk);
    n = 4'd5;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_opcode", opcode, 0);
    chk("abort_A", A, 0);
    chk("abort_B", B, 0);
    repeat (40) @(negedge clk);
    t = runs_done;
    @(negedge clk);
    n = 4'd3;
    start = 1;
    sb.push_back('{4'd2, 14});
    sb.push_back('{4'd2, 38});
    repeat (4) @(negedge clk);
    n = 4'd9;
    wait_runs(t + 1);
    @(negedge clk);
    @(negedge clk);
    start = 0;
    wait_runs(t + 2);
    repeat (3) @(negedge clk);
    chk("b2b_runs", runs_done, t + 2);
    for (int k = 0; k < 16; k++) run(4'(k));
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
